// File: rtl/motor_pkg.sv
// Shared definitions for the stepper motion blocks: move FSM states,
// direction encoding and default datapath widths.
package motor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } move_state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  localparam int DEFAULT_STEP_W = 16;
  localparam int DEFAULT_POS_W  = 24;

endpackage

// File: rtl/step_edge_det.sv
// Rising-edge detector for the phase controller step clock; `pulse` is high
// for the single cycle in which step_in is 1 and was 0 the cycle before.
module step_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic step_in,
  output logic pulse
);

  logic step_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q <= 1'b0;
    end else begin
      step_q <= step_in;
    end
  end

  assign pulse = step_in & ~step_q;

endmodule

// File: rtl/move_sequencer.sv
// Move sequencer: takes step-count/direction commands, gates the phase
// controller enable, counts step edges and keeps a signed absolute position.
// Build option MOVE_SEQ_TIMEOUT_EN adds a step-gap watchdog and a `timeout` port.
module move_sequencer
  import motor_pkg::*;
#(
  parameter int STEP_W         = DEFAULT_STEP_W,
  parameter int POS_W          = DEFAULT_POS_W,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [STEP_W-1:0]       cmd_steps,
  input  logic                    cmd_dir,
  input  logic                    abort,
  input  logic                    step_in,
  output logic                    enable,
  output logic                    dir,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted,
`ifdef MOVE_SEQ_TIMEOUT_EN
  output logic                    timeout,
`endif
  output logic signed [POS_W-1:0] position
);

  // Command handshake: a command transfers in any cycle where cmd_valid and
  // cmd_ready are both 1; cmd_ready depends only on state, never on cmd_valid.

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  move_state_t             state_q, state_d;
  logic [STEP_W-1:0]       remaining_q;
  logic [SETTLE_W-1:0]     settle_q;
  logic                    dir_q;
  logic                    aborted_q;
  logic signed [POS_W-1:0] position_q;
  logic                    step_edge;
  logic                    accept;
  logic                    in_run;
  logic                    in_move;
  logic                    tmo_hit;
  logic                    stop_early;

  step_edge_det u_step_edge (
    .clk     (clk),
    .rst     (rst),
    .step_in (step_in),
    .pulse   (step_edge)
  );

  assign accept  = (state_q == IDLE) && cmd_valid;
  assign in_run  = (state_q == RUN);
  assign in_move = (state_q == SETTLE) || in_run;

`ifdef MOVE_SEQ_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] gap_q;
  logic             timeout_q;

  // gap_q counts RUN cycles since entry or since the last step edge.
  assign tmo_hit = in_run && !step_edge && (gap_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      gap_q     <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      gap_q     <= '0;
      timeout_q <= 1'b0;
    end else if (in_run) begin
      gap_q <= step_edge ? '0 : gap_q + TMO_W'(1);
      if (tmo_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign timeout = (state_q == DONE) && timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo_hit = 1'b0;
`endif

  assign stop_early = in_move && (abort || tmo_hit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d = (cmd_steps == '0) ? DONE : SETTLE;
        end
      end
      SETTLE: begin
        if (stop_early) begin
          state_d = DONE;
        end else if (settle_q == SETTLE_LAST) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_early || (step_edge && (remaining_q == STEP_W'(1)))) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      settle_q    <= '0;
      dir_q       <= DIR_REV;
      aborted_q   <= 1'b0;
      position_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        remaining_q <= cmd_steps;
        dir_q       <= cmd_dir;
        aborted_q   <= 1'b0;
        settle_q    <= '0;
      end
      if (state_q == SETTLE) begin
        settle_q <= settle_q + SETTLE_W'(1);
      end
      // An edge coinciding with abort is still a step the motor took.
      if (in_run && step_edge) begin
        remaining_q <= remaining_q - STEP_W'(1);
        position_q  <= (dir_q == DIR_FWD) ? position_q + POS_W'(1)
                                          : position_q - POS_W'(1);
      end
      if (stop_early) begin
        aborted_q <= 1'b1;
      end
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign enable    = in_run;
  assign busy      = in_move;
  assign done      = (state_q == DONE);
  assign dir       = dir_q;
  assign aborted   = aborted_q;
  assign position  = position_q;

endmodule
